mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-003 SHALL have ports mem_aluop (in, 8, op code), mem_addr (in, 32, effective address), mem_reg2 (in, 32, store data), mem_wd (in, 5, dest reg), mem_wreg (in, 1, dest write enable), mem_wdata (in, 32, ALU result); all driven from the EX/MEM pipeline register.
REQ-004 SHALL have ports flush (in, 1, pipeline flush) and wb_stall (in, 1, MEM/WB register held).
REQ-005 SHALL have bus ports bus_req (out, 1), bus_we (out, 1), bus_addr (out, 32, word-aligned), bus_sel (out, 4, byte lanes), bus_wdata (out, 32), bus_ack (in, 1), bus_rdata (in, 32).
REQ-006 SHALL have outputs wb_wd (5), wb_wreg (1), wb_wdata (32), stallreq (1, freeze stages 0-4), adel (1, load address error), ades (1, store address error), bus_err (1).

Function
REQ-007 SHALL recognise memory ops EXE_LB/LBU/LH/LHU/LW (load) and EXE_SB/SH/SW (store); every other aluop passes through: wb_* = mem_*, stallreq=0, no bus activity.
REQ-008 SHALL implement FSM IDLE, BUSY, DONE, ABORT; reset state IDLE.
REQ-009 IDLE with aligned memory op at cycle T: stallreq=1 combinationally in T; next state BUSY; bus_req=1 from T+1.
REQ-010 BUSY: bus_req, bus_we, bus_addr, bus_sel, bus_wdata SHALL be registered and stable until the cycle bus_ack=1; stallreq=1.
REQ-011 BUSY with bus_ack: capture bus_rdata into a 32-bit buffer; bus_req=0 next cycle; next state DONE. Ack at T+k (k>=1) gives DONE at T+k+1, stallreq low at T+k+1.
REQ-012 DONE: stallreq=0; wb_wd=mem_wd, wb_wreg=mem_wreg, wb_wdata=extended buffer (loads) or mem_wdata (stores); stays DONE while wb_stall=1, else IDLE.
REQ-013 Big-endian lanes: addr[1:0]=00 selects bits 31:24 (sel 1000), 01->23:16, 10->15:8, 11->7:0; halfword 00->1100, 10->0011; word sel 1111; bus_addr = {mem_addr[31:2],2'b00}.
REQ-014 Stores SHALL replicate data: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW reg2.
REQ-015 LB/LH SHALL sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-016 Misalignment (LH/LHU addr[0]=1; LW addr[1:0]!=0; SH addr[0]=1; SW addr[1:0]!=0): no bus request, adel or ades=1 combinationally, wb_wreg=0, stallreq=0, stay IDLE.
REQ-017 In IDLE/BUSY/ABORT with a memory op, wb_wreg SHALL be 0.
REQ-018 flush in BUSY without ack: next state ABORT; bus_req held until ack; data discarded. flush in BUSY with ack: next IDLE, data discarded. flush in DONE: next IDLE.
REQ-019 ABORT: on bus_ack -> IDLE; stallreq=1 iff a memory op is presented, stalling it until IDLE.
REQ-020 flush in IDLE SHALL start no transaction that cycle.

Reset
REQ-021 Reset SHALL force asynchronously: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_sel=0, bus_wdata=0, buffer=0, bus_err=0, timeout counter=0; reset mid-BUSY drops bus_req immediately.
REQ-022 During reset stallreq, wb_wreg, adel, ades SHALL be 0 and wb_wd=0, wb_wdata=0.

Configuration
REQ-023 Macro LSU_BUS_TIMEOUT_EN defined: 8-bit counter runs in BUSY/ABORT; at 255 cycles without ack -> IDLE, bus_req=0, one-cycle bus_err=1, wb_wreg=0, stallreq=0 that cycle.
REQ-024 LSU_BUS_TIMEOUT_EN undefined: no counter, bus_err tied 0, BUSY waits indefinitely.

Verification
REQ-025 LW addr 0x100, ack at T+2 with rdata 0xDEADBEEF -> bus_req T+1..T+2, sel 1111, stallreq T..T+2, DONE T+3 wb_wdata 0xDEADBEEF.
REQ-026 LB addr 0x103, rdata 0x123456F0 -> sel 0001, wb_wdata 0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-027 SH addr 0x202, reg2 0xAAAA1234 -> bus_we=1, sel 0011, bus_wdata 0x12341234, bus_addr 0x200.
REQ-028 LW addr 0x101 -> adel=1, bus_req=0, stallreq=0, wb_wreg=0; SW 0x102 -> ades=1.
REQ-029 flush at T+1 of LW, ack T+4, new LW presented T+2 -> bus_req held to T+4, stallreq high T+2..T+4, new request starts T+6.
REQ-030 With LSU_BUS_TIMEOUT_EN, never ack -> bus_err=1 exactly 255 cycles after bus_req rises, state IDLE.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a single-outstanding req/ack bus, big-endian lanes.
// Define LSU_BUS_TIMEOUT_EN to enable the 255-cycle bus watchdog and the bus_err pulse.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  input  logic        wb_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);
  localparam logic [7:0] EXE_LB  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU = 8'b1110_0101;
  localparam logic [7:0] EXE_SB  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW  = 8'b1110_1011;

  typedef enum logic [1:0] {StIdle, StBusy, StDone, StAbort} state_e;
  state_e state_q;

  logic [31:0] rbuf_q;
  logic        is_load, is_store, is_mem, misalign, start, timeout, err_hold;
  logic [3:0]  sel;
  logic [31:0] st_data, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign is_mem = is_load | is_store;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    sel      = 4'b0000;
    st_data  = mem_reg2;
    case (mem_aluop)
      EXE_LB, EXE_LBU: begin
        is_load = 1'b1;
        sel     = 4'b1000 >> mem_addr[1:0];
      end
      EXE_LH, EXE_LHU: begin
        is_load  = 1'b1;
        misalign = mem_addr[0];
        sel      = mem_addr[1] ? 4'b0011 : 4'b1100;
      end
      EXE_LW: begin
        is_load  = 1'b1;
        misalign = |mem_addr[1:0];
        sel      = 4'b1111;
      end
      EXE_SB: begin
        is_store = 1'b1;
        sel      = 4'b1000 >> mem_addr[1:0];
        st_data  = {4{mem_reg2[7:0]}};
      end
      EXE_SH: begin
        is_store = 1'b1;
        misalign = mem_addr[0];
        sel      = mem_addr[1] ? 4'b0011 : 4'b1100;
        st_data  = {2{mem_reg2[15:0]}};
      end
      EXE_SW: begin
        is_store = 1'b1;
        misalign = |mem_addr[1:0];
        sel      = 4'b1111;
      end
      default: ;
    endcase
  end

  // Lane extraction relies on EX/MEM holding the op while this unit stalls or sits in DONE.
  always_comb begin
    case (mem_addr[1:0])
      2'b00:   ld_byte = rbuf_q[31:24];
      2'b01:   ld_byte = rbuf_q[23:16];
      2'b10:   ld_byte = rbuf_q[15:8];
      default: ld_byte = rbuf_q[7:0];
    endcase
    ld_half = mem_addr[1] ? rbuf_q[15:0] : rbuf_q[31:16];
    case (mem_aluop)
      EXE_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU: ld_data = {24'h0, ld_byte};
      EXE_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      EXE_LHU: ld_data = {16'h0, ld_half};
      default: ld_data = rbuf_q;
    endcase
  end

`ifdef LSU_BUS_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       bus_err_q;

  // Count 0..254 over 255 waiting cycles; the last one without ack retires the access.
  assign timeout  = (tmo_cnt_q == 8'd254) & ~bus_ack;
  assign err_hold = bus_err_q;
  assign bus_err  = bus_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= (state_q == StBusy || state_q == StAbort) && timeout;
      if ((state_q == StBusy || state_q == StAbort) && !bus_ack && !timeout) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end else begin
        tmo_cnt_q <= 8'd0;
      end
    end
  end
`else
  assign timeout  = 1'b0;
  assign err_hold = 1'b0;
  assign bus_err  = 1'b0;
`endif

  assign start = (state_q == StIdle) && is_mem && !misalign && !flush && !err_hold;

  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = mem_wreg;
    wb_wdata = mem_wdata;
    stallreq = 1'b0;
    adel     = 1'b0;
    ades     = 1'b0;
    if (rst) begin
      wb_wd    = 5'd0;
      wb_wreg  = 1'b0;
      wb_wdata = 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (is_mem) begin
            wb_wreg  = 1'b0;
            stallreq = start;
            adel     = is_load & misalign & ~flush;
            ades     = is_store & misalign & ~flush;
          end
          if (err_hold) wb_wreg = 1'b0;
        end
        StBusy: begin
          stallreq = 1'b1;
          if (is_mem) wb_wreg = 1'b0;
        end
        StDone: begin
          if (is_load) wb_wdata = ld_data;
        end
        default: begin
          if (is_mem) begin
            stallreq = 1'b1;
            wb_wreg  = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_sel   <= 4'd0;
      bus_wdata <= 32'd0;
      rbuf_q    <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StBusy;
            bus_req   <= 1'b1;
            bus_we    <= is_store;
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= sel;
            bus_wdata <= is_store ? st_data : 32'd0;
          end
        end
        StBusy: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (flush) begin
              state_q <= StIdle;
            end else begin
              rbuf_q  <= bus_rdata;
              state_q <= StDone;
            end
          end else if (timeout) begin
            bus_req <= 1'b0;
            state_q <= StIdle;
          end else if (flush) begin
            state_q <= StAbort;
          end
        end
        StDone: begin
          if (flush || !wb_stall) state_q <= StIdle;
        end
        default: begin
          if (bus_ack || timeout) begin
            bus_req <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, hand sequences, random transactions.
module tb_mem_lsu;
  localparam logic [7:0] LB  = 8'b1110_0000;
  localparam logic [7:0] LH  = 8'b1110_0001;
  localparam logic [7:0] LW  = 8'b1110_0011;
  localparam logic [7:0] LBU = 8'b1110_0100;
  localparam logic [7:0] LHU = 8'b1110_0101;
  localparam logic [7:0] SB  = 8'b1110_1000;
  localparam logic [7:0] SH  = 8'b1110_1001;
  localparam logic [7:0] SW  = 8'b1110_1011;
  localparam logic [7:0] NOP = 8'h00;
  localparam logic [31:0] WDATA = 32'h0BAD_F00D;

  logic        clk, rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_addr, mem_reg2, mem_wdata;
  logic [4:0]  mem_wd;
  logic        mem_wreg, flush, wb_stall;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;
  logic        wb_wreg, stallreq, adel, ades, bus_err;
  logic [31:0] wb_wdata;

  int errors = 0;
  int checks = 0;

  mem_lsu dut (
    .clk(clk), .rst(rst), .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_reg2(mem_reg2),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .flush(flush),
    .wb_stall(wb_stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq(stallreq),
    .adel(adel), .ades(ades), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          dly;
    logic [3:0]  sel;
    logic [31:0] bwd;
    logic [31:0] res;
    bit          mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    mem_aluop = NOP; mem_addr = 0; mem_reg2 = 0; mem_wd = 0; mem_wreg = 0; mem_wdata = 0;
    flush = 0; wb_stall = 0; bus_ack = 0; bus_rdata = 0;
  endtask

  // Transaction-level reference: what the bus and writeback must show for one access.
  function automatic void model(input logic [7:0] op, input logic [31:0] addr, reg2, rdata,
                                output logic [3:0] sel, output logic [31:0] bwd, res,
                                output bit mis);
    int b, sh, hs;
    logic [31:0] bv, hv;
    b   = int'(addr[1:0]);
    sh  = 8 * (3 - b);
    hs  = (b >= 2) ? 0 : 16;
    bv  = (rdata >> sh) & 32'hFF;
    hv  = (rdata >> hs) & 32'hFFFF;
    sel = 4'h0; bwd = 32'h0; res = WDATA; mis = 0;
    case (op)
      LB:  begin sel = 4'(1 << (3 - b)); res = bv[7] ? (bv | 32'hFFFF_FF00) : bv; end
      LBU: begin sel = 4'(1 << (3 - b)); res = bv; end
      LH:  begin mis = (b % 2) != 0; sel = (b < 2) ? 4'hC : 4'h3;
                 res = hv[15] ? (hv | 32'hFFFF_0000) : hv; end
      LHU: begin mis = (b % 2) != 0; sel = (b < 2) ? 4'hC : 4'h3; res = hv; end
      LW:  begin mis = b != 0; sel = 4'hF; res = rdata; end
      SB:  begin sel = 4'(1 << (3 - b)); bwd = {24'h0, reg2[7:0]} * 32'h0101_0101; end
      SH:  begin mis = (b % 2) != 0; sel = (b < 2) ? 4'hC : 4'h3;
                 bwd = {16'h0, reg2[15:0]} * 32'h0001_0001; end
      SW:  begin mis = b != 0; sel = 4'hF; bwd = reg2; end
      default: ;
    endcase
  endfunction

  // Starts in IDLE just after a rising edge; ends back in IDLE just after a rising edge.
  task automatic run_txn(input logic [7:0] op, input logic [31:0] addr, reg2, rdata,
                         input int dly, input logic [3:0] e_sel, input logic [31:0] e_bwd,
                         input logic [31:0] e_res, input bit e_mis);
    bit st;
    st = (op == SB) || (op == SH) || (op == SW);
    mem_aluop = op; mem_addr = addr; mem_reg2 = reg2; mem_wd = 5'd7; mem_wreg = 1'b1;
    mem_wdata = WDATA; bus_ack = 0;
    #4;
    if (e_mis) begin
      chk("mis_adel", adel, !st);
      chk("mis_ades", ades, st);
      chk("mis_stallreq", stallreq, 0);
      chk("mis_wb_wreg", wb_wreg, 0);
      tick;
      chk("mis_bus_req", bus_req, 0);
      idle_inputs;
      return;
    end
    chk("start_stallreq", stallreq, 1);
    chk("start_bus_req", bus_req, 0);
    chk("start_wb_wreg", wb_wreg, 0);
    for (int k = 1; k <= dly; k++) begin
      tick;
      bus_ack = (k == dly);
      bus_rdata = rdata;
      #4;
      chk("busy_bus_req", bus_req, 1);
      chk("busy_bus_we", bus_we, st);
      chk("busy_bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
      chk("busy_bus_sel", bus_sel, e_sel);
      if (st) chk("busy_bus_wdata", bus_wdata, e_bwd);
      chk("busy_stallreq", stallreq, 1);
      chk("busy_wb_wreg", wb_wreg, 0);
    end
    tick;
    bus_ack = 0;
    #4;
    chk("done_bus_req", bus_req, 0);
    chk("done_stallreq", stallreq, 0);
    chk("done_wb_wreg", wb_wreg, 1);
    chk("done_wb_wd", wb_wd, 7);
    chk("done_wb_wdata", wb_wdata, e_res);
    tick;
    idle_inputs;
  endtask

  task automatic run_pass(input logic [7:0] op);
    logic [4:0] wd;
    logic wr;
    logic [31:0] wdat;
    wd = 5'($urandom); wr = 1'($urandom); wdat = $urandom;
    mem_aluop = op; mem_wd = wd; mem_wreg = wr; mem_wdata = wdat;
    #4;
    chk("pass_wb_wd", wb_wd, wd);
    chk("pass_wb_wreg", wb_wreg, wr);
    chk("pass_wb_wdata", wb_wdata, wdat);
    chk("pass_stallreq", stallreq, 0);
    tick;
    chk("pass_bus_req", bus_req, 0);
    idle_inputs;
  endtask

  initial begin
    vec_t vecs[11];
    logic [7:0] ops[8];
    logic [7:0] op;
    logic [31:0] addr, reg2, rdata, bwd, res;
    logic [3:0] sel;
    bit mis;
    int r, n;

    vecs[0]  = '{LW,  32'h100, 32'h0,         32'hDEAD_BEEF, 2, 4'hF, 32'h0,         32'hDEAD_BEEF, 0};
    vecs[1]  = '{LB,  32'h103, 32'h0,         32'h1234_56F0, 1, 4'h1, 32'h0,         32'hFFFF_FFF0, 0};
    vecs[2]  = '{LBU, 32'h103, 32'h0,         32'h1234_56F0, 3, 4'h1, 32'h0,         32'h0000_00F0, 0};
    vecs[3]  = '{SH,  32'h202, 32'hAAAA_1234, 32'h0,         1, 4'h3, 32'h1234_1234, WDATA,         0};
    vecs[4]  = '{LW,  32'h101, 32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0,         1};
    vecs[5]  = '{SW,  32'h102, 32'h5,         32'h0,         1, 4'h0, 32'h0,         32'h0,         1};
    vecs[6]  = '{LH,  32'h200, 32'h0,         32'h8001_7FFF, 2, 4'hC, 32'h0,         32'hFFFF_8001, 0};
    vecs[7]  = '{LHU, 32'h202, 32'h0,         32'h8001_F00F, 1, 4'h3, 32'h0,         32'h0000_F00F, 0};
    vecs[8]  = '{SB,  32'h301, 32'h0000_0055, 32'h0,         2, 4'h4, 32'h5555_5555, WDATA,         0};
    vecs[9]  = '{LB,  32'h300, 32'h0,         32'h7F00_0000, 1, 4'h8, 32'h0,         32'h0000_007F, 0};
    vecs[10] = '{LH,  32'h201, 32'h0,         32'h0,         1, 4'h0, 32'h0,         32'h0,         1};
    ops = '{LB, LBU, LH, LHU, LW, SB, SH, SW};

    // Reset with a load presented: outputs forced quiet.
    idle_inputs;
    rst = 1;
    mem_aluop = LW; mem_addr = 32'h100; mem_wd = 5'd3; mem_wreg = 1; mem_wdata = WDATA;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stallreq", stallreq, 0);
    chk("rst_wb_wreg", wb_wreg, 0);
    chk("rst_wb_wd", wb_wd, 0);
    chk("rst_wb_wdata", wb_wdata, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_sel", bus_sel, 0);
    chk("rst_bus_err", bus_err, 0);
    rst = 0;
    idle_inputs;
    tick;

    foreach (vecs[i])
      run_txn(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].rdata, vecs[i].dly,
              vecs[i].sel, vecs[i].bwd, vecs[i].res, vecs[i].mis);

    // Flush presented in IDLE starts nothing.
    mem_aluop = LW; mem_addr = 32'h400; mem_wreg = 1; flush = 1;
    #4;
    chk("fidle_stallreq", stallreq, 0);
    tick;
    chk("fidle_bus_req", bus_req, 0);
    idle_inputs;

    // Flush together with ack: data dropped, straight back to IDLE.
    mem_aluop = LW; mem_addr = 32'h404; mem_wreg = 1; mem_wdata = WDATA;
    tick;
    bus_ack = 1; flush = 1; bus_rdata = 32'h1111_2222;
    tick;
    bus_ack = 0; flush = 0; mem_aluop = NOP;
    #4;
    chk("fack_bus_req", bus_req, 0);
    chk("fack_stallreq", stallreq, 0);
    chk("fack_wb_wdata", wb_wdata, WDATA);
    tick;
    idle_inputs;

    // Flush mid-access then a new load waits out the abandoned access.
    mem_aluop = LW; mem_addr = 32'h100; mem_wd = 5'd7; mem_wreg = 1; mem_wdata = WDATA;
    tick;
    flush = 1;
    tick;
    flush = 0; mem_addr = 32'h300;
    #4;
    chk("abort2_stallreq", stallreq, 1);
    chk("abort2_bus_req", bus_req, 1);
    chk("abort2_bus_addr", bus_addr, 32'h100);
    chk("abort2_wb_wreg", wb_wreg, 0);
    tick;
    #4;
    chk("abort3_bus_req", bus_req, 1);
    chk("abort3_stallreq", stallreq, 1);
    tick;
    bus_ack = 1; bus_rdata = 32'h9999_9999;
    #4;
    chk("abort4_stallreq", stallreq, 1);
    chk("abort4_bus_req", bus_req, 1);
    tick;
    bus_ack = 0;
    #4;
    chk("abort5_bus_req", bus_req, 0);
    chk("abort5_stallreq", stallreq, 1);
    tick;
    #4;
    chk("abort6_bus_req", bus_req, 1);
    chk("abort6_bus_addr", bus_addr, 32'h300);
    bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
    tick;
    bus_ack = 0;
    #4;
    chk("abort7_wb_wdata", wb_wdata, 32'hCAFE_F00D);
    tick;
    idle_inputs;

    // wb_stall holds DONE and its writeback data.
    mem_aluop = LW; mem_addr = 32'h500; mem_wd = 5'd9; mem_wreg = 1; mem_wdata = WDATA;
    tick;
    bus_ack = 1; bus_rdata = 32'h1122_3344;
    tick;
    bus_ack = 0; wb_stall = 1;
    #4;
    chk("hold0_wb_wdata", wb_wdata, 32'h1122_3344);
    tick;
    wb_stall = 0;
    #4;
    chk("hold1_wb_wdata", wb_wdata, 32'h1122_3344);
    chk("hold1_wb_wreg", wb_wreg, 1);
    chk("hold1_stallreq", stallreq, 0);
    chk("hold1_bus_req", bus_req, 0);
    tick;
    mem_aluop = NOP;
    #4;
    chk("hold2_wb_wdata", wb_wdata, WDATA);
    tick;
    idle_inputs;

    // Asynchronous reset mid-access drops bus_req without a clock edge.
    mem_aluop = LW; mem_addr = 32'h600; mem_wreg = 1;
    tick;
    #2;
    chk("arst_pre_bus_req", bus_req, 1);
    rst = 1;
    #1;
    chk("arst_bus_req", bus_req, 0);
    chk("arst_stallreq", stallreq, 0);
    @(posedge clk);
    #1;
    rst = 0;
    idle_inputs;
    tick;

`ifdef LSU_BUS_TIMEOUT_EN
    mem_aluop = LW; mem_addr = 32'h700; mem_wreg = 1;
    tick;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      #4;
      if (bus_err === 1'b1) break;
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmo_cycles", n, 255);
    chk("tmo_bus_req", bus_req, 0);
    chk("tmo_stallreq", stallreq, 0);
    chk("tmo_wb_wreg", wb_wreg, 0);
    idle_inputs;
    tick;
    chk("tmo_err_pulse", bus_err, 0);
`else
    mem_aluop = LW; mem_addr = 32'h700; mem_wd = 5'd7; mem_wreg = 1; mem_wdata = WDATA;
    tick;
    repeat (300) tick;
    #4;
    chk("wait_bus_req", bus_req, 1);
    chk("wait_bus_err", bus_err, 0);
    chk("wait_stallreq", stallreq, 1);
    bus_ack = 1; bus_rdata = 32'h0F0F_0F0F;
    tick;
    bus_ack = 0;
    #4;
    chk("wait_wb_wdata", wb_wdata, 32'h0F0F_0F0F);
    tick;
    idle_inputs;
`endif

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 8) begin
        run_pass(8'h25 + 8'(r));
      end else begin
        op = ops[r]; addr = $urandom; reg2 = $urandom; rdata = $urandom;
        model(op, addr, reg2, rdata, sel, bwd, res, mis);
        run_txn(op, addr, reg2, rdata, $urandom_range(1, 4), sel, bwd, res, mis);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
